// File: rtl/bellek_hakemi.sv
// bellek_hakemi: round-robin arbiter/sequencer for a shared single-port memory.
// Two requesters: getir (fetch, read-only) and veri (data stage, read/write).
// Each accepted transaction gets exactly one memory access cycle (ERISIM),
// optionally preceded by GECIKME wait cycles (BEKLE). The combinational read
// data is registered into a one-cycle response pulse for the owner.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   g_istek_gecerli/_hazir, g_adres    fetch request handshake + address
//   g_veri, g_veri_gecerli             fetch response (registered, 1-cycle pulse)
//   v_istek_gecerli/_hazir, v_adres,
//   v_yaz, v_yaz_veri                  data-stage request handshake, address, write
//   v_veri, v_veri_gecerli             data-stage response (pre-write data on writes)
//   bellek_adres, bellek_yaz_veri,
//   bellek_yaz_gecerli, bellek_oku_veri  memory side
module bellek_hakemi #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32,
    parameter int GECIKME   = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 g_istek_gecerli,
    output logic                 g_istek_hazir,
    input  logic [ADRES_BIT-1:0] g_adres,
    output logic [VERI_BIT-1:0]  g_veri,
    output logic                 g_veri_gecerli,
    input  logic                 v_istek_gecerli,
    output logic                 v_istek_hazir,
    input  logic [ADRES_BIT-1:0] v_adres,
    input  logic                 v_yaz,
    input  logic [VERI_BIT-1:0]  v_yaz_veri,
    output logic [VERI_BIT-1:0]  v_veri,
    output logic                 v_veri_gecerli,
    output logic [ADRES_BIT-1:0] bellek_adres,
    input  logic [VERI_BIT-1:0]  bellek_oku_veri,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
    output logic                 bellek_yaz_gecerli
);

    typedef enum logic [1:0] {BOSTA, BEKLE, ERISIM} durum_t;

    localparam int         GEC_M1 = (GECIKME > 0) ? GECIKME - 1 : 0;
    localparam logic [3:0] YUKLE  = GEC_M1[3:0];

    durum_t                durum_q, durum_d;
    logic                  son_q, son_d;      // 1: veri won the last grant
    logic                  sahip_q, sahip_d;  // 1: current transaction belongs to veri
    logic                  yaz_q, yaz_d;
    logic [ADRES_BIT-1:0]  adres_q, adres_d;
    logic [VERI_BIT-1:0]   yveri_q, yveri_d;
    logic [3:0]            sayac_q, sayac_d;
    logic [VERI_BIT-1:0]   g_veri_q, g_veri_d, v_veri_q, v_veri_d;
    logic                  g_gec_q, g_gec_d, v_gec_q, v_gec_d;
    logic                  g_kazan, v_kazan;

    // On a tie the requester that did not win last time gets the grant.
    assign g_kazan = (durum_q == BOSTA) && g_istek_gecerli && (!v_istek_gecerli || son_q);
    assign v_kazan = (durum_q == BOSTA) && v_istek_gecerli && (!g_istek_gecerli || !son_q);

    always_comb begin
        durum_d  = durum_q;
        son_d    = son_q;
        sahip_d  = sahip_q;
        yaz_d    = yaz_q;
        adres_d  = adres_q;
        yveri_d  = yveri_q;
        sayac_d  = sayac_q;
        g_veri_d = g_veri_q;
        v_veri_d = v_veri_q;
        g_gec_d  = 1'b0;
        v_gec_d  = 1'b0;
        case (durum_q)
            BOSTA: begin
                if (g_kazan || v_kazan) begin
                    adres_d = v_kazan ? v_adres : g_adres;
                    yaz_d   = v_kazan & v_yaz;    // fetch can never write
                    yveri_d = v_yaz_veri;
                    sahip_d = v_kazan;
                    son_d   = v_kazan;
                    sayac_d = YUKLE;
                    durum_d = (GECIKME > 0) ? BEKLE : ERISIM;
                end
            end
            BEKLE: begin
                if (sayac_q == 4'd0) durum_d = ERISIM;
                else                 sayac_d = sayac_q - 4'd1;
            end
            ERISIM: begin
                if (sahip_q) begin
                    v_veri_d = bellek_oku_veri;
                    v_gec_d  = 1'b1;
                end else begin
                    g_veri_d = bellek_oku_veri;
                    g_gec_d  = 1'b1;
                end
                durum_d = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            durum_q  <= BOSTA;
            son_q    <= 1'b1;   // fetch wins the first tie
            sahip_q  <= 1'b0;
            yaz_q    <= 1'b0;
            adres_q  <= '0;
            yveri_q  <= '0;
            sayac_q  <= '0;
            g_veri_q <= '0;
            v_veri_q <= '0;
            g_gec_q  <= 1'b0;
            v_gec_q  <= 1'b0;
        end else begin
            durum_q  <= durum_d;
            son_q    <= son_d;
            sahip_q  <= sahip_d;
            yaz_q    <= yaz_d;
            adres_q  <= adres_d;
            yveri_q  <= yveri_d;
            sayac_q  <= sayac_d;
            g_veri_q <= g_veri_d;
            v_veri_q <= v_veri_d;
            g_gec_q  <= g_gec_d;
            v_gec_q  <= v_gec_d;
        end
    end

    assign g_istek_hazir   = g_kazan;
    assign v_istek_hazir   = v_kazan;
    assign g_veri          = g_veri_q;
    assign g_veri_gecerli  = g_gec_q;
    assign v_veri          = v_veri_q;
    assign v_veri_gecerli  = v_gec_q;
    assign bellek_adres    = adres_q;
    assign bellek_yaz_veri = yveri_q;
    // Decoded from async-reset state, so the strobe drops the moment rstn falls.
    assign bellek_yaz_gecerli = (durum_q == ERISIM) && yaz_q;

endmodule

// File: tb/tb_bellek_hakemi.sv
// Bench for bellek_hakemi: three instances (GECIKME = 0, 2, 3), each with its
// own word memory model indexed by address bits [9:2]. A shadow copy of each
// memory gives expected read data; latency is derived from 2+GECIKME.
module tb_bellek_hakemi;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rstn;
    logic gv [N], vv [N], vy [N];
    logic [31:0] ga [N], va [N], vwd [N];
    logic gh [N], vh [N], ggec [N], vgec [N], byg [N];
    logic [31:0] gd [N], vd [N], badr [N], bwd [N], boku [N];
    logic [31:0] mem [N][256];
    logic [31:0] shadow [N][256];
    int nstr [N];
    logic sync, nclr;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    function automatic int gk(int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_dut
            bellek_hakemi #(.ADRES_BIT(32), .VERI_BIT(32),
                            .GECIKME((k == 0) ? 0 : ((k == 1) ? 2 : 3))) u_dut (
                .clk(clk), .rstn(rstn),
                .g_istek_gecerli(gv[k]), .g_istek_hazir(gh[k]), .g_adres(ga[k]),
                .g_veri(gd[k]), .g_veri_gecerli(ggec[k]),
                .v_istek_gecerli(vv[k]), .v_istek_hazir(vh[k]), .v_adres(va[k]),
                .v_yaz(vy[k]), .v_yaz_veri(vwd[k]), .v_veri(vd[k]), .v_veri_gecerli(vgec[k]),
                .bellek_adres(badr[k]), .bellek_oku_veri(boku[k]),
                .bellek_yaz_veri(bwd[k]), .bellek_yaz_gecerli(byg[k]));
            assign boku[k] = mem[k][badr[k][9:2]];
        end
    endgenerate

    // Memory models: bulk copy from shadow while idle, otherwise DUT writes.
    always @(posedge clk) begin
        if (sync) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < 256; j++) mem[i][j] <= shadow[i][j];
        end else begin
            for (int i = 0; i < N; i++)
                if (byg[i] === 1'b1) mem[i][badr[i][9:2]] <= bwd[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (nclr) nstr[i] <= 0;
            else if (byg[i] === 1'b1) nstr[i] <= nstr[i] + 1;
        end
    end

    task automatic sync_mem;
        @(posedge clk); #1; sync = 1'b1;
        @(posedge clk); #1; sync = 1'b0;
    endtask

    task automatic pulse_reset;
        @(posedge clk); #1; rstn = 1'b0;
        for (int i = 0; i < N; i++) begin gv[i] = 0; vv[i] = 0; vy[i] = 0; end
        @(posedge clk); #1; rstn = 1'b1;
    endtask

    // One transaction on instance kk; checks accept, strobe/pulse timing and data.
    task automatic do_tx(input int kk, input bit port, input bit yaz,
                         input logic [31:0] adr, input logic [31:0] wd, input string nm);
        int g;
        bit ok;
        logic [31:0] ex, d;
        logic [2:0] got, want;
        g = gk(kk);
        @(posedge clk); #1;
        if (port) begin vv[kk] = 1; vy[kk] = yaz; va[kk] = adr; vwd[kk] = wd; end
        else begin gv[kk] = 1; ga[kk] = adr; end
        ok = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if ((port ? vh[kk] : gh[kk]) === 1'b1) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s accept k=%0d: hazir never seen within 20 cycles", nm, kk);
            gv[kk] = 0; vv[kk] = 0;
            return;
        end
        ex = shadow[kk][adr[9:2]];
        if (port && yaz) shadow[kk][adr[9:2]] = wd;
        @(posedge clk); #1;
        gv[kk] = 0; vv[kk] = 0; ga[kk] = $urandom; va[kk] = $urandom; vwd[kk] = $urandom;
        for (int c = 1; c <= g + 2; c++) begin
            @(negedge clk);
            got  = {ggec[kk], vgec[kk], byg[kk]};
            want = {(c == g + 2) && !port, (c == g + 2) && port, (c == g + 1) && port && yaz};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s timing k=%0d cyc=%0d {g_gec,v_gec,yaz}: got=%b want=%b", nm, kk, c, got, want);
            end
            if (c == g + 1) begin
                total++;
                if (badr[kk] !== adr) begin
                    bad++;
                    $display("FAIL %s bellek_adres k=%0d: got=%h want=%h", nm, kk, badr[kk], adr);
                end
            end
            if (c == g + 2) begin
                d = port ? vd[kk] : gd[kk];
                total++;
                if (d !== ex) begin
                    bad++;
                    $display("FAIL %s data k=%0d: got=%h want=%h", nm, kk, d, ex);
                end
            end
            if (c < g + 2) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset;
        logic [132:0] vec;
        repeat (2) @(posedge clk);
        sync_mem();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            vec = {gh[i], vh[i], ggec[i], vgec[i], byg[i], gd[i], vd[i], badr[i], bwd[i]};
            total++;
            if (vec !== '0) begin
                bad++;
                $display("FAIL reset_outputs k=%0d: got=%h want=0", i, vec);
            end
        end
        // first cycle with rstn high: both request, fetch must win
        @(posedge clk); #1;
        rstn = 1'b1; gv[2] = 1; vv[2] = 1; vy[2] = 0; ga[2] = $urandom; va[2] = $urandom;
        @(negedge clk);
        total++;
        if ({gh[2], vh[2]} !== 2'b10) begin
            bad++;
            $display("FAIL reset_first_tie {g_hazir,v_hazir}: got=%b want=10", {gh[2], vh[2]});
        end
        @(posedge clk); #1; gv[2] = 0; vv[2] = 0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_fetch_read;
        shadow[0][8'h04] = 32'hDEAD_BEEF;
        sync_mem();
        gv[0] = 1; ga[0] = 32'h8000_0010;
        @(negedge clk);
        total++;
        if (gh[0] !== 1'b1) begin bad++; $display("FAIL fetch_hazir: got=%b want=1", gh[0]); end
        @(posedge clk); #1; gv[0] = 0; ga[0] = $urandom;
        @(negedge clk);
        total++;
        if (badr[0] !== 32'h8000_0010 || ggec[0] !== 1'b0) begin
            bad++; $display("FAIL fetch_T1 adr/gec: got=%h/%b want=80000010/0", badr[0], ggec[0]);
        end
        @(posedge clk); #1; @(negedge clk);
        total++;
        if (ggec[0] !== 1'b1 || gd[0] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL fetch_T2 gec/data: got=%b/%h want=1/deadbeef", ggec[0], gd[0]);
        end
        @(posedge clk); #1; @(negedge clk);
        total++;
        if (ggec[0] !== 1'b0) begin bad++; $display("FAIL fetch_T3 gec: got=%b want=0", ggec[0]); end
    endtask

    task automatic test_write_read;
        shadow[2][8'h08] = 32'h0;
        sync_mem();
        vv[2] = 1; vy[2] = 1; va[2] = 32'h8000_0020; vwd[2] = 32'h1234_5678;
        @(negedge clk);
        total++;
        if (vh[2] !== 1'b1) begin bad++; $display("FAIL wr_hazir: got=%b want=1", vh[2]); end
        @(posedge clk); #1; vv[2] = 0; vy[2] = 0; va[2] = $urandom; vwd[2] = $urandom;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++;
            if ({byg[2], vgec[2]} !== {c == 4, c == 5}) begin
                bad++; $display("FAIL wr_timing cyc=%0d {yaz,v_gec}: got=%b%b want=%b%b", c, byg[2], vgec[2], c == 4, c == 5);
            end
            if (c == 5) begin
                total++;
                if (vd[2] !== 32'h0) begin bad++; $display("FAIL wr_old_data: got=%h want=0", vd[2]); end
            end
            if (c < 5) begin @(posedge clk); #1; end
        end
        shadow[2][8'h08] = 32'h1234_5678;
        do_tx(2, 1'b0, 1'b0, 32'h8000_0020, 32'h0, "wr_readback");
    endtask

    task automatic test_fairness;
        bit pp, want_g;
        logic [31:0] pex, a;
        pulse_reset();
        gv[0] = 1; vv[0] = 1; vy[0] = $urandom % 2; ga[0] = $urandom; va[0] = $urandom; vwd[0] = $urandom;
        pp = 0; pex = 0;
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            if (n > 0) begin
                total++;
                if ({ggec[0], vgec[0]} !== {!pp, pp} || (pp ? vd[0] : gd[0]) !== pex) begin
                    bad++;
                    $display("FAIL rr_resp n=%0d {g_gec,v_gec}/data: got=%b%b/%h want=%b%b/%h",
                             n, ggec[0], vgec[0], pp ? vd[0] : gd[0], !pp, pp, pex);
                end
            end
            if (n < 8) begin
                want_g = (n % 2 == 0);
                total++;
                if ({gh[0], vh[0]} !== {want_g, !want_g}) begin
                    bad++; $display("FAIL rr_grant n=%0d {g,v}: got=%b%b want=%b%b", n, gh[0], vh[0], want_g, !want_g);
                end
                a = want_g ? ga[0] : va[0];
                pp = !want_g;
                pex = shadow[0][a[9:2]];
                if (!want_g && vy[0]) shadow[0][a[9:2]] = vwd[0];
                @(posedge clk); #1;
                if (want_g) ga[0] = $urandom;
                else begin va[0] = $urandom; vy[0] = $urandom % 2; vwd[0] = $urandom; end
                @(negedge clk);
                total++;
                if ({gh[0], vh[0], ggec[0], vgec[0]} !== 4'b0) begin
                    bad++; $display("FAIL rr_busy n=%0d {gh,vh,gg,vg}: got=%b%b%b%b want=0000", n, gh[0], vh[0], ggec[0], vgec[0]);
                end
                @(posedge clk); #1;
                if (n == 7) begin gv[0] = 0; vv[0] = 0; end
            end
        end
    endtask

    task automatic test_fetch_no_write;
        int nw;
        bit p, y;
        nw = 0;
        @(posedge clk); #1; nclr = 1;
        @(posedge clk); #1; nclr = 0;
        for (int n = 0; n < 10; n++) begin
            p = (n % 3 == 1) ? 1'b1 : 1'(($urandom % 4) == 0);
            y = (n % 3 == 1) ? 1'b1 : 1'($urandom % 2);
            if (!p) begin vy[1] = 1; vwd[1] = $urandom; end
            if (p && y) nw++;
            do_tx(1, p, y, $urandom, $urandom, "nowr");
        end
        @(posedge clk); #1; @(negedge clk);
        total++;
        if (nstr[1] !== nw) begin bad++; $display("FAIL nowr_strobes: got=%0d want=%0d", nstr[1], nw); end
        vy[1] = 0;
    endtask

    task automatic test_drop;
        logic [31:0] a, ex;
        a = $urandom; ex = shadow[1][a[9:2]];
        @(posedge clk); #1; gv[1] = 1; ga[1] = a;
        @(negedge clk);
        total++;
        if (gh[1] !== 1'b1) begin bad++; $display("FAIL drop_fetch_hazir: got=%b want=1", gh[1]); end
        @(posedge clk); #1; gv[1] = 0; vv[1] = 1; vy[1] = 1; va[1] = $urandom; vwd[1] = $urandom;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if (vh[1] !== 1'b0) begin bad++; $display("FAIL drop_busy_hazir cyc=%0d: got=%b want=0", c, vh[1]); end
            @(posedge clk); #1;
        end
        vv[1] = 0; vy[1] = 0;
        @(negedge clk);
        total++;
        if (ggec[1] !== 1'b1 || gd[1] !== ex) begin
            bad++; $display("FAIL drop_fetch_resp: got=%b/%h want=1/%h", ggec[1], gd[1], ex);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1; @(negedge clk);
            total++;
            if (vgec[1] !== 1'b0 || byg[1] !== 1'b0) begin
                bad++; $display("FAIL drop_no_tx cyc=%0d {v_gec,yaz}: got=%b%b want=00", c, vgec[1], byg[1]);
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++)
            do_tx(n % N, 1'($urandom % 2), 1'($urandom % 2), $urandom, $urandom, "rand");
    endtask

    task automatic test_reset_mid;
        logic [31:0] a, old;
        logic [132:0] vec;
        a = $urandom; old = shadow[1][a[9:2]];
        @(posedge clk); #1; vv[1] = 1; vy[1] = 1; va[1] = a; vwd[1] = ~old;
        @(negedge clk);
        total++;
        if (vh[1] !== 1'b1) begin bad++; $display("FAIL rmid_hazir: got=%b want=1", vh[1]); end
        @(posedge clk); #1; vv[1] = 0; vy[1] = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (byg[1] !== 1'b1) begin bad++; $display("FAIL rmid_strobe_before: got=%b want=1", byg[1]); end
        rstn = 1'b0;
        #1;
        total++;
        if (byg[1] !== 1'b0) begin bad++; $display("FAIL rmid_strobe_async: got=%b want=0", byg[1]); end
        @(posedge clk); #1;
        total++;
        if (mem[1][a[9:2]] !== old) begin bad++; $display("FAIL rmid_mem: got=%h want=%h", mem[1][a[9:2]], old); end
        @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);
        vec = {gh[1], vh[1], ggec[1], vgec[1], byg[1], gd[1], vd[1], badr[1], bwd[1]};
        total++;
        if (vec !== '0) begin bad++; $display("FAIL rmid_outputs: got=%h want=0", vec); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1; @(negedge clk);
            total++;
            if (vgec[1] !== 1'b0) begin bad++; $display("FAIL rmid_no_resp cyc=%0d: got=%b want=0", c, vgec[1]); end
        end
    endtask

    initial begin
        rstn = 1'b0; sync = 1'b0; nclr = 1'b1;
        for (int i = 0; i < N; i++) begin
            gv[i] = 0; vv[i] = 0; vy[i] = 0; ga[i] = 0; va[i] = 0; vwd[i] = 0;
            for (int j = 0; j < 256; j++) shadow[i][j] = $urandom;
        end
        @(posedge clk); #1; nclr = 1'b0;
        test_reset();
        test_fetch_read();
        test_write_read();
        test_fairness();
        test_fetch_no_write();
        test_drop();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
